// File: rtl/display_scan_driver_if.sv
// rtl/display_scan_driver_if.sv - digit/mask inputs and segment/anode outputs of the scan driver
interface display_scan_driver_if;
  logic [3:0] in_digit0;
  logic [3:0] in_digit1;
  logic [3:0] in_digit2;
  logic [3:0] in_digit3;
  logic [3:0] in_blink_mask;
  logic [7:0] out_seg;
  logic [3:0] out_an;
  logic       out_blink_phase;

  // Source of the BCD digits and consumer of the display drive
  modport master (
    output in_digit0, in_digit1, in_digit2, in_digit3, in_blink_mask,
    input  out_seg, out_an, out_blink_phase
  );

  // The scan driver itself
  modport slave (
    input  in_digit0, in_digit1, in_digit2, in_digit3, in_blink_mask,
    output out_seg, out_an, out_blink_phase
  );
endinterface

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - four-digit common-anode 7-segment scanner with guard and blink
module display_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 12500000
) (
  input logic                 in_clock,
  input logic                 in_reset,
  display_scan_driver_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [BW-1:0] bcnt;
  logic          phase;

  logic [3:0]    digit;
  logic [7:0]    seg_dec;
  logic          in_guard;
  logic          blanked;

  // Select the BCD digit for the slot currently being scanned (inputs are live, never latched)
  always_comb begin
    digit = bus.in_digit0;
    case (idx)
      2'd0: digit = bus.in_digit0;
      2'd1: digit = bus.in_digit1;
      2'd2: digit = bus.in_digit2;
      2'd3: digit = bus.in_digit3;
      default: digit = bus.in_digit0;
    endcase
  end

  // BCD to active-low segments {dp,g,f,e,d,c,b,a}; non-BCD codes show a blank digit
  always_comb begin
    seg_dec = 8'hFF;
    case (digit)
      4'd0: seg_dec = 8'hC0;
      4'd1: seg_dec = 8'hF9;
      4'd2: seg_dec = 8'hA4;
      4'd3: seg_dec = 8'hB0;
      4'd4: seg_dec = 8'h99;
      4'd5: seg_dec = 8'h92;
      4'd6: seg_dec = 8'h82;
      4'd7: seg_dec = 8'hF8;
      4'd8: seg_dec = 8'h80;
      4'd9: seg_dec = 8'h90;
      default: seg_dec = 8'hFF;
    endcase
  end

  // With no guard window the comparison would be against zero, so it is elided entirely
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (32'(cnt) < GUARD);
    end
  endgenerate

  // Blinking digits keep their anode on but show no segments during the off phase
  assign blanked = bus.in_blink_mask[idx] && !phase;

  // Slot and blink timebases; both run free and only reset restarts them
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      cnt   <= '0;
      idx   <= 2'd0;
      bcnt  <= '0;
      phase <= 1'b1;
    end else begin
      if (cnt == CW'(SCAN_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Registered display drive; a single anode pattern register means two digits can never overlap
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      bus.out_an          <= 4'b1111;
      bus.out_seg         <= 8'hFF;
      bus.out_blink_phase <= 1'b1;
    end else begin
      bus.out_blink_phase <= phase;
      if (in_guard) begin
        bus.out_an  <= 4'b1111;
        bus.out_seg <= 8'hFF;
      end else begin
        bus.out_an  <= ~(4'b0001 << idx);
        bus.out_seg <= blanked ? 8'hFF : seg_dec;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - self-checking bench for display_scan_driver
module tb_display_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int GUARD     = 1;
  localparam int BLINK_DIV = 8;

  logic in_clock = 1'b0;
  logic in_reset;

  display_scan_driver_if bus ();

  display_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .in_clock(in_clock),
    .in_reset(in_reset),
    .bus     (bus.slave)
  );

  always #5 in_clock = ~in_clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: non-reset edges since the last reset
  int n = 0;
  bit model_valid = 0;
  int last_k = 0;
  int last_pos = 0;
  bit last_rst = 0;

  typedef struct {
    logic [3:0] d3, d2, d1, d0;
    logic [3:0] mask;
    logic [7:0] seg [4];
  } vec_t;

  vec_t vecs [6];

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] lut [10];
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    if (d > 4'd9) return 8'hFF;
    return lut[d];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0, input logic [3:0] mask);
    bus.in_digit3     = d3;
    bus.in_digit2     = d2;
    bus.in_digit1     = d1;
    bus.in_digit0     = d0;
    bus.in_blink_mask = mask;
  endtask

  // One clock: predict from the model, take the edge, compare #1 later, advance the model
  task automatic cycle();
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic       e_ph;
    logic [3:0] dig [4];
    bit         chk;
    int         k, pos;
    bit         ph;
    chk = model_valid || in_reset;
    dig = '{bus.in_digit0, bus.in_digit1, bus.in_digit2, bus.in_digit3};
    k   = (n / SCAN_DIV) % 4;
    pos = n % SCAN_DIV;
    ph  = ((n / BLINK_DIV) % 2) == 0;
    if (in_reset) begin
      e_seg = 8'hFF; e_an = 4'hF; e_ph = 1'b1;
    end else begin
      e_ph = ph;
      if (pos < GUARD) begin
        e_seg = 8'hFF; e_an = 4'hF;
      end else begin
        e_an  = 4'hF & ~(4'(1) << k);
        e_seg = (bus.in_blink_mask[k] && !ph) ? 8'hFF : seg_of(dig[k]);
      end
    end
    last_k   = k;
    last_pos = pos;
    last_rst = in_reset;
    @(posedge in_clock);
    #1;
    if (chk) begin
      check("model_seg", 32'(bus.out_seg), 32'(e_seg));
      check("model_an", 32'(bus.out_an), 32'(e_an));
      check("model_phase", 32'(bus.out_blink_phase), 32'(e_ph));
    end
    if (in_reset) begin
      n = 0;
      model_valid = 1;
    end else begin
      n++;
    end
  endtask

  task automatic do_reset(input int cycles);
    in_reset = 1'b1;
    for (int i = 0; i < cycles; i++) cycle();
    in_reset = 1'b0;
  endtask

  // Never more than one anode on, checked on every cycle away from the active edge
  always @(negedge in_clock) begin
    if (model_valid) begin
      checks++;
      if ($countones(~bus.out_an) > 1) begin
        errors++;
        $display("FAIL one_hot_an: got %b expected at most one low bit at %0t", bus.out_an, $time);
      end
    end
  end

  initial begin
    vecs[0] = '{d3:4'd1, d2:4'd2, d1:4'd5, d0:4'd9, mask:4'b0000, seg:'{8'h90, 8'h92, 8'hA4, 8'hF9}};
    vecs[1] = '{d3:4'd1, d2:4'd2, d1:4'd5, d0:4'd9, mask:4'b1100, seg:'{8'h90, 8'h92, 8'hFF, 8'hFF}};
    vecs[2] = '{d3:4'd8, d2:4'd7, d1:4'd6, d0:4'hA, mask:4'b0000, seg:'{8'hFF, 8'h82, 8'hF8, 8'h80}};
    vecs[3] = '{d3:4'd0, d2:4'd3, d1:4'd4, d0:4'd0, mask:4'b0011, seg:'{8'hC0, 8'h99, 8'hB0, 8'hC0}};
    vecs[4] = '{d3:4'hF, d2:4'hB, d1:4'hC, d0:4'hD, mask:4'b0000, seg:'{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[5] = '{d3:4'd1, d2:4'd2, d1:4'd5, d0:4'd9, mask:4'b1111, seg:'{8'h90, 8'h92, 8'hFF, 8'hFF}};

    in_reset = 1'b1;
    set_digits(4'd1, 4'd2, 4'd5, 4'd9, 4'b0000);

    // Reset held three cycles, then the first post-release cycle is still dark
    do_reset(3);
    check("reset_an", 32'(bus.out_an), 32'hF);
    check("reset_seg", 32'(bus.out_seg), 32'hFF);
    check("reset_phase", 32'(bus.out_blink_phase), 32'h1);
    cycle();
    check("post_release_an", 32'(bus.out_an), 32'hF);
    check("post_release_seg", 32'(bus.out_seg), 32'hFF);
    check("post_release_phase", 32'(bus.out_blink_phase), 32'h1);

    // Table: one full scan from reset per vector; digits 2/3 fall in blink phase 0
    for (int v = 0; v < 6; v++) begin
      do_reset(1);
      set_digits(vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0, vecs[v].mask);
      for (int c = 0; c < 16; c++) begin
        cycle();
        if (last_pos == 2) begin
          check($sformatf("tbl%0d_seg_d%0d", v, last_k), 32'(bus.out_seg), 32'(vecs[v].seg[last_k]));
          check($sformatf("tbl%0d_an_d%0d", v, last_k), 32'(bus.out_an), 32'(4'hF & ~(4'(1) << last_k)));
        end
      end
    end

    // Blink phase toggles every 8 cycles over a longer run
    do_reset(1);
    set_digits(4'd1, 4'd2, 4'd5, 4'd9, 4'b1100);
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (c % 8 == 7) check("blink_phase_period", 32'(bus.out_blink_phase), 32'(((c / 8) % 2) == 0));
    end

    // Mid-slot reset during digit 2 restarts the scan at digit 0 with a guard cycle
    do_reset(1);
    set_digits(4'd1, 4'd2, 4'd5, 4'd9, 4'b0000);
    while (n < 10) cycle();
    check("mid_pre_an", 32'(bus.out_an), 32'b1011);
    in_reset = 1'b1;
    cycle();
    in_reset = 1'b0;
    check("mid_reset_an", 32'(bus.out_an), 32'hF);
    check("mid_reset_seg", 32'(bus.out_seg), 32'hFF);
    cycle();
    check("mid_guard_an", 32'(bus.out_an), 32'hF);
    cycle();
    check("mid_restart_an", 32'(bus.out_an), 32'b1110);
    check("mid_restart_seg", 32'(bus.out_seg), 32'h90);
    check("mid_restart_phase", 32'(bus.out_blink_phase), 32'h1);

    // Live digit change inside the digit-1 slot shows one cycle later
    do_reset(1);
    set_digits(4'd1, 4'd2, 4'd3, 4'd9, 4'b0000);
    while (n < 6) cycle();
    check("live_before_seg", 32'(bus.out_seg), 32'hB0);
    check("live_before_an", 32'(bus.out_an), 32'b1101);
    bus.in_digit1 = 4'd7;
    cycle();
    check("live_after_seg", 32'(bus.out_seg), 32'hF8);
    check("live_after_an", 32'(bus.out_an), 32'b1101);

    // Randomized inputs with occasional resets against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)));
      in_reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    in_reset = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
